// File: rtl/div_sequencer.sv
// div_sequencer: request/response front-end for a free-running 32-cycle
// sequential divider. Divide-by-zero and signed overflow are answered
// locally; all other requests go through the divider.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  IDLE  | req_ready=1, waiting for a request
//  ARM   | div_* driven, waiting for the divider's ready pulse (load edge)
//  BUSY  | divider running, waiting for its next ready pulse (result edge)
//  RESP  | rsp_valid=1, payload held until rsp_ready
module div_sequencer #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_dividend,
  input  logic [31:0]      req_divisor,
  input  logic             req_sign,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      div_dividend,
  output logic [31:0]      div_divider,
  output logic             div_sign,
  input  logic             div_ready,
  input  logic [31:0]      div_quotient,
  input  logic [31:0]      div_remainder,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_quotient,
  output logic [31:0]      rsp_remainder,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_dbz,
  output logic             rsp_ovf
);

  typedef enum logic [1:0] {IDLE, ARM, BUSY, RESP} state_t;

  state_t state, state_nxt;
  logic   busy_first;
  logic   accept;
  logic   is_dbz;
  logic   is_ovf;
  logic   load;
  logic   capture;

  assign accept  = (state == IDLE) && req_valid;
  assign is_dbz  = (req_divisor == 32'h0);
  assign is_ovf  = req_sign && (req_dividend == 32'h8000_0000) &&
                   (req_divisor == 32'hFFFF_FFFF);
  // The divider's ready is already low in the cycle after the load, but it is
  // masked anyway so a slow-falling ready can never be mistaken for the result.
  assign load    = (state == ARM) && div_ready;
  assign capture = (state == BUSY) && !busy_first && div_ready;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = (is_dbz || is_ovf) ? RESP : ARM;
      ARM:  if (div_ready) state_nxt = BUSY;
      BUSY: if (capture)   state_nxt = RESP;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // Marks the first BUSY cycle, right after the divider load edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_first <= 1'b0;
    else     busy_first <= load;
  end

  // Divider operand registers; held constant from ARM through BUSY.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_dividend <= 32'h0;
      div_divider  <= 32'h0;
      div_sign     <= 1'b0;
    end else if (accept && !is_dbz && !is_ovf) begin
      div_dividend <= req_dividend;
      div_divider  <= req_divisor;
      div_sign     <= req_sign;
    end
  end

  // Response payload: fast-path results at accept, divider results at capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_quotient  <= 32'h0;
      rsp_remainder <= 32'h0;
      rsp_tag       <= '0;
      rsp_dbz       <= 1'b0;
      rsp_ovf       <= 1'b0;
    end else if (accept) begin
      rsp_tag <= req_tag;
      rsp_dbz <= is_dbz;
      rsp_ovf <= is_ovf && !is_dbz;
      if (is_dbz) begin
        rsp_quotient  <= 32'hFFFF_FFFF;
        rsp_remainder <= req_dividend;
      end else if (is_ovf) begin
        rsp_quotient  <= 32'h8000_0000;
        rsp_remainder <= 32'h0;
      end
    end else if (capture) begin
      rsp_quotient  <= div_quotient;
      rsp_remainder <= div_remainder;
    end
  end

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer with a behavioural free-running divider:
// ready pulses for one cycle every 33 cycles, operands load on that edge, and
// the result appears with the next ready pulse.
module tb_div_sequencer;

  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [31:0]      req_dividend = '0;
  logic [31:0]      req_divisor = '0;
  logic             req_sign = 1'b0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      div_dividend;
  logic [31:0]      div_divider;
  logic             div_sign;
  logic             div_ready;
  logic [31:0]      div_quotient;
  logic [31:0]      div_remainder;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [31:0]      rsp_quotient;
  logic [31:0]      rsp_remainder;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_dbz;
  logic             rsp_ovf;

  int total = 0;
  int bad = 0;

  div_sequencer #(.TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_sign(req_sign), .req_tag(req_tag),
    .div_dividend(div_dividend), .div_divider(div_divider), .div_sign(div_sign),
    .div_ready(div_ready), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_tag(rsp_tag), .rsp_dbz(rsp_dbz), .rsp_ovf(rsp_ovf)
  );

  always #5 clk = ~clk;

  // Divider model (no reset, free-running)
  int          m_cnt = 0;
  logic [31:0] m_lq = '0, m_lr = '0, m_q = '0, m_r = '0;

  assign div_ready     = (m_cnt == 0);
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  always @(posedge clk) begin
    if (m_cnt == 0) begin
      m_cnt <= 1;
      if (div_divider == 32'h0) begin
        m_lq <= 32'hFFFF_FFFF;
        m_lr <= div_dividend;
      end else if (div_sign && div_dividend == 32'h8000_0000 && div_divider == 32'hFFFF_FFFF) begin
        m_lq <= 32'h8000_0000;
        m_lr <= 32'h0;
      end else if (div_sign) begin
        m_lq <= $signed(div_dividend) / $signed(div_divider);
        m_lr <= $signed(div_dividend) % $signed(div_divider);
      end else begin
        m_lq <= div_dividend / div_divider;
        m_lr <= div_dividend % div_divider;
      end
    end else if (m_cnt == 32) begin
      m_cnt <= 0;
      m_q   <= m_lq;
      m_r   <= m_lr;
    end else begin
      m_cnt <= m_cnt + 1;
    end
  end

  // Present a request for one edge; returns #1 after the accept edge.
  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic s, input logic [TAG_W-1:0] t);
    req_dividend = a;
    req_divisor  = b;
    req_sign     = s;
    req_tag      = t;
    req_valid    = 1'b1;
    @(posedge clk); #1;
    req_valid    = 1'b0;
  endtask

  // Count edges until rsp_valid, bounded.
  task automatic wait_rsp(input int budget, output int n);
    n = 0;
    while (!rsp_valid && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Accept the response with a single-edge handshake.
  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic check_rsp(input string name, input logic [31:0] q, input logic [31:0] r,
                           input logic [TAG_W-1:0] t, input logic dbz, input logic ovf);
    total++;
    if (rsp_valid !== 1'b1 || rsp_quotient !== q || rsp_remainder !== r ||
        rsp_tag !== t || rsp_dbz !== dbz || rsp_ovf !== ovf) begin
      bad++;
      $display("FAIL %s: got v=%b q=%h r=%h tag=%h dbz=%b ovf=%b, want v=1 q=%h r=%h tag=%h dbz=%b ovf=%b",
               name, rsp_valid, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, rsp_ovf,
               q, r, t, dbz, ovf);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || rsp_quotient !== 32'h0 ||
        rsp_remainder !== 32'h0 || rsp_tag !== '0 || rsp_dbz !== 1'b0 || rsp_ovf !== 1'b0) begin
      bad++;
      $display("FAIL reset_rsp: got v=%b rdy=%b q=%h r=%h tag=%h dbz=%b ovf=%b, want v=0 rdy=1 rest 0",
               rsp_valid, req_ready, rsp_quotient, rsp_remainder, rsp_tag, rsp_dbz, rsp_ovf);
    end
    total++;
    if (div_dividend !== 32'h0 || div_divider !== 32'h0 || div_sign !== 1'b0) begin
      bad++;
      $display("FAIL reset_div: got %h %h %b, want 0 0 0", div_dividend, div_divider, div_sign);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_latency();
    int n, g;
    g = 0;
    while (m_cnt != 32 && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    issue(32'd10000, 32'd1000, 1'b1, 4'hA);
    wait_rsp(120, n);
    total++;
    if (n !== 34) begin
      bad++;
      $display("FAIL basic_latency: got %0d edges, want 34", n);
    end
    check_rsp("basic_10000_1000", 32'd10, 32'd0, 4'hA, 1'b0, 1'b0);
    consume();
  endtask

  task automatic test_dbz();
    int n;
    issue(32'd5, 32'd0, 1'b0, 4'h3);
    wait_rsp(5, n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL dbz_latency: got %0d edges, want 0", n);
    end
    check_rsp("dbz_5_0", 32'hFFFF_FFFF, 32'd5, 4'h3, 1'b1, 1'b0);
    total++;
    if (div_dividend !== 32'd10000 || div_divider !== 32'd1000 || div_sign !== 1'b1) begin
      bad++;
      $display("FAIL dbz_div_untouched: got %h %h %b, want 00002710 000003e8 1",
               div_dividend, div_divider, div_sign);
    end
    consume();
  endtask

  task automatic test_ovf();
    int n;
    issue(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 4'h5);
    wait_rsp(5, n);
    total++;
    if (n !== 0) begin
      bad++;
      $display("FAIL ovf_latency: got %0d edges, want 0", n);
    end
    check_rsp("ovf_intmin_m1", 32'h8000_0000, 32'h0, 4'h5, 1'b0, 1'b1);
    consume();
  endtask

  task automatic test_signedness();
    int n;
    issue(32'hFFFF_FFF9, 32'd2, 1'b1, 4'h6);
    wait_rsp(120, n);
    check_rsp("signed_m7_2", 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'h6, 1'b0, 1'b0);
    consume();
    issue(32'hFFFF_FFF9, 32'd2, 1'b0, 4'h7);
    wait_rsp(120, n);
    check_rsp("unsigned_m7_2", 32'h7FFF_FFFC, 32'd1, 4'h7, 1'b0, 1'b0);
    consume();
  endtask

  task automatic test_backpressure();
    int n;
    int unstable;
    issue(32'd100, 32'd10, 1'b0, 4'h9);
    wait_rsp(120, n);
    check_rsp("bp_first", 32'd10, 32'd0, 4'h9, 1'b0, 1'b0);
    req_dividend = 32'd1; req_divisor = 32'd0; req_tag = 4'h1; req_valid = 1'b1;
    unstable = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_quotient !== 32'd10 || rsp_remainder !== 32'd0 ||
          rsp_tag !== 4'h9 || rsp_dbz !== 1'b0 || req_ready !== 1'b0)
        unstable++;
    end
    total++;
    if (unstable !== 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d unstable cycles, want 0", unstable);
    end
    req_valid = 1'b0;
    consume();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_release: got v=%b rdy=%b, want v=0 rdy=1", rsp_valid, req_ready);
    end
    @(posedge clk); #1;
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_single: got v=%b, want 0", rsp_valid);
    end
  endtask

  task automatic test_reset_mid_busy();
    int n, g, seen;
    issue(32'd50, 32'd5, 1'b0, 4'hC);
    g = 0;
    while (!div_ready && g < 40) begin
      @(posedge clk); #1;
      g++;
    end
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || div_dividend !== 32'h0) begin
      bad++;
      $display("FAIL rst_busy: got v=%b rdy=%b divd=%h, want v=0 rdy=1 divd=0",
               rsp_valid, req_ready, div_dividend);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL rst_dropped: got %0d valid cycles, want 0", seen);
    end
    issue(32'd100, 32'd7, 1'b0, 4'hD);
    wait_rsp(120, n);
    total++;
    if (n > 67) begin
      bad++;
      $display("FAIL rst_realign_timeout: got %0d edges, want at most 67", n);
    end
    check_rsp("rst_100_7", 32'd14, 32'd2, 4'hD, 1'b0, 1'b0);
    consume();
  endtask

  initial begin
    test_reset();
    test_basic_latency();
    test_dbz();
    test_ovf();
    test_signedness();
    test_backpressure();
    test_reset_mid_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
